// File: rtl/traffic_pkg.sv
// Shared phase encodings, default minimum durations and the legal-successor rule
// for the traffic lamp monitor.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_OFF     = 3'd0,
    PH_MAIN_G  = 3'd1,
    PH_MAIN_Y  = 3'd2,
    PH_SIDE_G  = 3'd3,
    PH_SIDE_Y  = 3'd4,
    PH_WALK    = 3'd5,
    PH_ILLEGAL = 3'd7
  } phase_t;

  localparam int GRN_MIN_DEF  = 5;
  localparam int YEL_MIN_DEF  = 1;
  localparam int WALK_MIN_DEF = 2;

  localparam logic [4:0] SECS_MAX = 5'd31;

  // Dropping to OFF is always allowed; otherwise only the signal-plan order is.
  function automatic logic legal_step(phase_t from_ph, phase_t to_ph);
    logic ok;
    ok = 1'b0;
    if (to_ph == PH_OFF) begin
      ok = 1'b1;
    end else begin
      case (from_ph)
        PH_OFF:    ok = (to_ph == PH_MAIN_G);
        PH_MAIN_G: ok = (to_ph == PH_MAIN_Y);
        PH_MAIN_Y: ok = (to_ph == PH_SIDE_G) || (to_ph == PH_WALK);
        PH_WALK:   ok = (to_ph == PH_SIDE_G);
        PH_SIDE_G: ok = (to_ph == PH_SIDE_Y);
        PH_SIDE_Y: ok = (to_ph == PH_MAIN_G);
        default:   ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lamp_decoder.sv
// Combinational map from the seven registered lamp drives to a phase code.
// Bit order of lamps: {Gm, Ym, Rm, Gs, Ys, Rs, WalkLamp}.
module lamp_decoder
  import traffic_pkg::*;
(
  input  logic [6:0] lamps,
  output phase_t     phase_code
);

  // Exact-match decode; any other combination is a conflict.
  always_comb begin
    phase_code = PH_ILLEGAL;
    case (lamps)
      7'b000_0000: phase_code = PH_OFF;
      7'b100_0010: phase_code = PH_MAIN_G;
      7'b010_0010: phase_code = PH_MAIN_Y;
      7'b001_1000: phase_code = PH_SIDE_G;
      7'b001_0100: phase_code = PH_SIDE_Y;
      7'b001_0011: phase_code = PH_WALK;
      default:     phase_code = PH_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Watches controller lamp drives, tracks the current phase and its age, and
// raises sticky flags for lamp conflicts, bad sequencing and short phases.
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int GRN_MIN  = GRN_MIN_DEF,
  parameter int YEL_MIN  = YEL_MIN_DEF,
  parameter int WALK_MIN = WALK_MIN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       clr,
  input  logic       Gm,
  input  logic       Ym,
  input  logic       Rm,
  input  logic       Gs,
  input  logic       Ys,
  input  logic       Rs,
  input  logic       WalkLamp,
  output logic [2:0] phase,
  output logic [4:0] phase_secs,
  output logic [7:0] trans_cnt,
  output logic       err_conflict,
  output logic       err_seq,
  output logic       err_timing
);

  logic [6:0] lamps_r;
  phase_t     phase_r;
  phase_t     dec_s;
  logic [4:0] secs_r;
  logic [7:0] cnt_r;
  logic       conflict_r;
  logic       seq_r;
  logic       timing_r;

  logic       trans_s;
  logic       conflict_evt_s;
  logic       seq_evt_s;
  logic       timing_evt_s;
  logic [4:0] min_secs_s;

  // Single register stage on the raw lamp drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamps_r <= 7'd0;
    end else begin
      lamps_r <= {Gm, Ym, Rm, Gs, Ys, Rs, WalkLamp};
    end
  end

  lamp_decoder u_lamp_decoder (
    .lamps      (lamps_r),
    .phase_code (dec_s)
  );

  // Event detection; OFF and ILLEGAL carry a zero minimum so they are never timed.
  always_comb begin
    min_secs_s     = 5'd0;
    trans_s        = (dec_s != phase_r);
    conflict_evt_s = (dec_s == PH_ILLEGAL);
    case (phase_r)
      PH_MAIN_G, PH_SIDE_G: min_secs_s = 5'(GRN_MIN);
      PH_MAIN_Y, PH_SIDE_Y: min_secs_s = 5'(YEL_MIN);
      PH_WALK:              min_secs_s = 5'(WALK_MIN);
      default:              min_secs_s = 5'd0;
    endcase
    if (trans_s && (phase_r != PH_ILLEGAL) && (dec_s != PH_ILLEGAL)) begin
      seq_evt_s = !legal_step(phase_r, dec_s);
    end else begin
      seq_evt_s = 1'b0;
    end
    if (trans_s && (dec_s != PH_OFF)) begin
      timing_evt_s = (secs_r < min_secs_s);
    end else begin
      timing_evt_s = 1'b0;
    end
  end

  // Phase, phase age and transition count; a transition swallows a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= PH_OFF;
      secs_r  <= 5'd0;
      cnt_r   <= 8'd0;
    end else begin
      if (trans_s) begin
        phase_r <= dec_s;
        secs_r  <= 5'd0;
      end else if (sec_tick && (secs_r != SECS_MAX)) begin
        secs_r <= secs_r + 5'd1;
      end
      if (clr) begin
        cnt_r <= 8'd0;
      end else if (trans_s) begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end

  // Sticky flags: a new event in the clr cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_r <= 1'b0;
      seq_r      <= 1'b0;
      timing_r   <= 1'b0;
    end else begin
      conflict_r <= (conflict_r & ~clr) | conflict_evt_s;
      seq_r      <= (seq_r      & ~clr) | seq_evt_s;
      timing_r   <= (timing_r   & ~clr) | timing_evt_s;
    end
  end

  assign phase        = phase_r;
  assign phase_secs   = secs_r;
  assign trans_cnt    = cnt_r;
  assign err_conflict = conflict_r;
  assign err_seq      = seq_r;
  assign err_timing   = timing_r;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Self-checking bench: decode table, directed signal-plan scenarios and
// randomized lamp sequences checked against a behavioural model.
module tb_traffic_lamp_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic       clr = 1'b0;
  logic [6:0] lamps = 7'd0;   // {Gm, Ym, Rm, Gs, Ys, Rs, WalkLamp}
  logic [2:0] phase;
  logic [4:0] phase_secs;
  logic [7:0] trans_cnt;
  logic       err_conflict, err_seq, err_timing;

  traffic_lamp_monitor dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .clr(clr),
    .Gm(lamps[6]), .Ym(lamps[5]), .Rm(lamps[4]), .Gs(lamps[3]),
    .Ys(lamps[2]), .Rs(lamps[1]), .WalkLamp(lamps[0]),
    .phase(phase), .phase_secs(phase_secs), .trans_cnt(trans_cnt),
    .err_conflict(err_conflict), .err_seq(err_seq), .err_timing(err_timing)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] L_OFF   = 7'b000_0000;
  localparam logic [6:0] L_MG    = 7'b100_0010;
  localparam logic [6:0] L_MY    = 7'b010_0010;
  localparam logic [6:0] L_SG    = 7'b001_1000;
  localparam logic [6:0] L_SY    = 7'b001_0100;
  localparam logic [6:0] L_WALK  = 7'b001_0011;
  localparam logic [6:0] L_CONFL = 7'b100_1000;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [6:0] m_lamp;
  int m_phase, m_secs, m_cnt;
  bit m_conf, m_seq, m_tim;
  int last_phase;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int mdecode(logic [6:0] l);
    int n;
    n = $countones(l);
    if (n == 0) return 0;
    if (n == 2 && l[6] && l[1]) return 1;
    if (n == 2 && l[5] && l[1]) return 2;
    if (n == 2 && l[4] && l[3]) return 3;
    if (n == 2 && l[4] && l[2]) return 4;
    if (n == 3 && l[4] && l[1] && l[0]) return 5;
    return 7;
  endfunction

  function automatic bit mlegal(int a, int b);
    return (b == 0) || (a == 0 && b == 1) || (a == 1 && b == 2) ||
           (a == 2 && (b == 3 || b == 5)) || (a == 5 && b == 3) ||
           (a == 3 && b == 4) || (a == 4 && b == 1);
  endfunction

  function automatic int mminsec(int p);
    if (p == 1 || p == 3) return 5;
    if (p == 2 || p == 4) return 1;
    if (p == 5) return 2;
    return 0;
  endfunction

  task automatic model_clock(input bit tick, input bit c);
    int d;
    bit ce, se, te;
    d = mdecode(m_lamp);
    ce = (d == 7);
    se = 0;
    te = 0;
    if (d != m_phase) begin
      se = (d != 7) && (m_phase != 7) && !mlegal(m_phase, d);
      te = (d != 0) && (m_secs < mminsec(m_phase));
      m_cnt = (m_cnt + 1) % 256;
      m_secs = 0;
      m_phase = d;
    end else if (tick) begin
      m_secs = (m_secs + 1 > 31) ? 31 : m_secs + 1;
    end
    if (c) begin
      m_cnt = 0;
      m_conf = 0; m_seq = 0; m_tim = 0;
    end
    m_conf |= ce; m_seq |= se; m_tim |= te;
    m_lamp = lamps;
  endtask

  task automatic step(input logic [6:0] l, input bit tick, input bit c);
    @(negedge clk);
    lamps = l; sec_tick = tick; clr = c;
    @(posedge clk);
    model_clock(tick, c);
    #1;
    chk("phase", phase, m_phase);
    chk("phase_secs", phase_secs, m_secs);
    chk("trans_cnt", trans_cnt, m_cnt);
    chk("err_conflict", err_conflict, m_conf);
    chk("err_seq", err_seq, m_seq);
    chk("err_timing", err_timing, m_tim);
    if (int'(phase) != last_phase) chk("secs_on_transition", phase_secs, 0);
    last_phase = phase;
  endtask

  // One "second": a tick cycle followed by two quiet cycles.
  task automatic hold(input logic [6:0] l, input int secs);
    for (int s = 0; s < secs; s++) begin
      step(l, 1'b1, 1'b0);
      step(l, 1'b0, 1'b0);
      step(l, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    lamps = 7'd0; sec_tick = 1'b0; clr = 1'b0;
    #1;
    chk("rst_phase", phase, 0);
    chk("rst_secs", phase_secs, 0);
    chk("rst_cnt", trans_cnt, 0);
    chk("rst_flags", {err_conflict, err_seq, err_timing}, 0);
    m_lamp = 7'd0; m_phase = 0; m_secs = 0; m_cnt = 0;
    m_conf = 0; m_seq = 0; m_tim = 0; last_phase = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [6:0] lamps;
    int         exp_phase;
  } vec_t;
  vec_t tbl[10];

  logic [6:0] plan[6];

  initial begin
    tbl[0] = '{L_OFF, 0};   tbl[1] = '{L_MG, 1};     tbl[2] = '{L_MY, 2};
    tbl[3] = '{L_SG, 3};    tbl[4] = '{L_SY, 4};     tbl[5] = '{L_WALK, 5};
    tbl[6] = '{L_CONFL, 7}; tbl[7] = '{7'h7F, 7};    tbl[8] = '{7'b100_0000, 7};
    tbl[9] = '{7'b000_0001, 7};
    plan[0] = L_OFF; plan[1] = L_MG; plan[2] = L_MY;
    plan[3] = L_SG;  plan[4] = L_SY; plan[5] = L_WALK;

    do_reset();

    // Decode table
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].lamps, 1'b0, 1'b0);
      step(tbl[i].lamps, 1'b0, 1'b0);
      chk("decode_table", phase, tbl[i].exp_phase);
    end

    // Full legal cycle
    do_reset();
    hold(L_MG, 12); hold(L_MY, 2); hold(L_SG, 6); hold(L_SY, 2); hold(L_MG, 1);
    chk("cycle_trans_cnt", trans_cnt, 5);
    chk("cycle_flags", {err_conflict, err_seq, err_timing}, 0);

    // Lamp conflict, stickiness, clr vs. coincident event
    do_reset();
    hold(L_MG, 6);
    step(L_CONFL, 1'b0, 1'b0);
    step(L_CONFL, 1'b0, 1'b0);
    chk("conflict_phase", phase, 7);
    chk("conflict_flag", err_conflict, 1);
    step(L_CONFL, 1'b0, 1'b1);
    chk("conflict_clr_set_wins", err_conflict, 1);
    hold(L_MG, 3);
    chk("conflict_sticky", err_conflict, 1);
    step(L_MG, 1'b0, 1'b1);
    chk("conflict_cleared", err_conflict, 0);
    chk("clr_trans_cnt", trans_cnt, 0);

    // Illegal sequence MAIN_G -> SIDE_G
    do_reset();
    hold(L_MG, 6); hold(L_SG, 1);
    chk("seq_err", err_seq, 1);
    chk("seq_timing", err_timing, 0);

    // Short WALK
    do_reset();
    hold(L_MG, 6); hold(L_MY, 2); hold(L_WALK, 1); hold(L_SG, 1);
    chk("walk_timing", err_timing, 1);
    chk("walk_seq", err_seq, 0);

    // Tick on transition, then saturation
    do_reset();
    hold(L_MG, 6);
    step(L_MY, 1'b0, 1'b0);
    step(L_MY, 1'b1, 1'b0);
    chk("tick_on_trans", phase_secs, 0);
    for (int i = 0; i < 40; i++) step(L_MY, 1'b1, 1'b0);
    chk("secs_saturate", phase_secs, 31);

    // Reset mid-SIDE_G
    do_reset();
    hold(L_MG, 6); hold(L_MY, 2);
    step(L_SG, 1'b0, 1'b0);
    step(L_SG, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(L_SG, 1'b1, 1'b0);
    chk("pre_rst_secs", phase_secs, 3);
    do_reset();
    hold(L_MG, 2);
    chk("post_rst_phase", phase, 1);
    chk("post_rst_flags", {err_conflict, err_seq, err_timing}, 0);

    // Randomized lamp sequences
    do_reset();
    for (int seg = 0; seg < 300; seg++) begin
      logic [6:0] l;
      int len;
      if ($urandom_range(0, 9) == 0) l = 7'($urandom_range(0, 127));
      else l = plan[$urandom_range(0, 5)];
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) step(l, ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_monitor.md
TRAFFIC_LAMP_MONITOR -- requirements
Module: traffic_lamp_monitor

Interface
REQ-001 Parameters (name, default, meaning):
- GRN_MIN, 5: minimum green seconds.
- YEL_MIN, 1: minimum yellow seconds.
- WALK_MIN, 2: minimum walk seconds.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 sec_tick  in  1  one-cycle pulse per second, synchronous to clk.
REQ-005 clr  in  1  synchronous clear of sticky error flags and transition count.
REQ-006 Gm, Ym, Rm, Gs, Ys, Rs  in  1 each  main/side lamp drives from the controller.
REQ-007 WalkLamp  in  1  pedestrian lamp drive from the controller.
REQ-008 phase  out  3  decoded current phase.
REQ-009 phase_secs  out  5  whole seconds elapsed in the current phase.
REQ-010 trans_cnt  out  8  count of phase transitions, wrapping.
REQ-011 err_conflict  out  1  sticky; an illegal lamp combination was seen.
REQ-012 err_seq  out  1  sticky; an illegal phase transition was seen.
REQ-013 err_timing  out  1  sticky; a phase ended before its minimum duration.

Function
REQ-014 Lamp inputs are registered once; every decision uses the registered values, giving 1 clk of latency from lamp change to phase change.
REQ-015 Decode table (anything else decodes to ILLEGAL):
- OFF=0: all seven inputs 0.
- MAIN_G=1: Gm, Rs.
- MAIN_Y=2: Ym, Rs.
- SIDE_G=3: Rm, Gs.
- SIDE_Y=4: Rm, Ys.
- WALK=5: Rm, Rs, WalkLamp.
- ILLEGAL=7.
REQ-016 A decode of ILLEGAL sets err_conflict and loads phase=ILLEGAL.
REQ-017 Legal transitions:
- OFF->MAIN_G
- MAIN_G->MAIN_Y
- MAIN_Y->SIDE_G or WALK
- WALK->SIDE_G
- SIDE_G->SIDE_Y
- SIDE_Y->MAIN_G
- any->OFF
REQ-018 Any other change of decoded phase sets err_seq; transitions into or out of ILLEGAL do not set err_seq.
REQ-019 A transition is a cycle in which the decoded phase differs from phase; phase then loads the decoded value and trans_cnt increments by 1, wrapping 255->0.
REQ-020 On a transition, phase_secs loads 0; a coincident sec_tick is discarded.
REQ-021 Otherwise, phase_secs increments on sec_tick and saturates at 31.
REQ-022 Timing check, applied on the transition cycle to the old phase and the pre-transition phase_secs:
- MAIN_G or SIDE_G with phase_secs < GRN_MIN sets err_timing.
- MAIN_Y or SIDE_Y with phase_secs < YEL_MIN sets err_timing.
- WALK with phase_secs < WALK_MIN sets err_timing.
- OFF and ILLEGAL are never timed.
- A transition to OFF is never timed.
REQ-023 Error flags are sticky; they clear only on rst or clr.
REQ-024 clr zeroes the error flags and trans_cnt; clr does not affect phase or phase_secs.
REQ-025 If clr coincides with a new error event, the error flag ends the cycle set (set wins).

Reset
REQ-026 On rst assertion, outputs go immediately to:
- phase=OFF
- phase_secs=0
- trans_cnt=0
- all error flags 0
- lamp input registers 0
REQ-027 rst asserted mid-phase discards the elapsed time; no timing or sequence check is made on that event.
REQ-028 After rst deasserts, the first legal decode of MAIN_G counts as a normal OFF->MAIN_G transition.

Structure
REQ-029 Package traffic_pkg holds:
- phase encodings (OFF..ILLEGAL)
- default GRN_MIN, YEL_MIN and WALK_MIN values
REQ-030 One combinational sub-module, lamp_decoder, maps the seven registered lamps to a phase code.
REQ-031 Counters, checks and flags reside in traffic_lamp_monitor.

Verification
REQ-032 Drive the lamps through the cycle MAIN_G 12 s -> MAIN_Y 2 s -> SIDE_G 6 s -> SIDE_Y 2 s -> MAIN_G. Required: trans_cnt=5, all error flags 0, phase_secs=0 on each transition cycle.
REQ-033 Drive Gm=1 with Gs=1. Required: one clk after registration, phase=7 and err_conflict=1; err_conflict stays 1 after legal lamps resume and until clr.
REQ-034 Drive MAIN_G->SIDE_G directly. Required: err_seq=1, err_timing unaffected.
REQ-035 Drive MAIN_Y->WALK after 1 s in WALK, then ->SIDE_G. Required: err_timing=1 (1 < WALK_MIN=2).
REQ-036 Assert sec_tick on the same cycle as a transition. Required: phase_secs=0. Then hold one phase for 40 ticks. Required: phase_secs saturates at 31.
REQ-037 Assert rst mid-SIDE_G with phase_secs=3. Required: all outputs reset immediately; after release, OFF->MAIN_G sets no error.
